// File: rtl/filter_buffer_ctrl.sv
// Filter coefficient buffer sequencer: loads four 32-bit words from
// coefficient memory, then replays the 16 buffered bytes num_passes times.
module filter_buffer_ctrl #(
    parameter int ADDR_W = 8,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] filt_base_addr,
    input  logic [PASS_W-1:0] num_passes,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              filter_we,
    output logic              filter_re,
    output logic              rst_filter,
    input  logic              byte_ready,
    output logic              byte_valid,
    output logic [3:0]        byte_idx,
    output logic              pass_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        PRIME,
        STREAM,
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [1:0]        word_q, word_d;
    logic [3:0]        byte_q, byte_d;
    logic              byte_valid_q;
    logic [3:0]        byte_idx_q;
    logic              pass_last_q;
    logic              done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            pass_q       <= '0;
            word_q       <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_idx_q   <= '0;
            pass_last_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pass_q       <= pass_d;
            word_q       <= word_d;
            byte_q       <= byte_d;
            // Aligned with the buffer's registered byte output
            byte_valid_q <= filter_re;
            byte_idx_q   <= byte_q;
            pass_last_q  <= filter_re && (pass_q == PASS_W'(1));
            done_q       <= (state_d == FINISH);
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        pass_d     = pass_q;
        word_d     = word_q;
        byte_d     = byte_q;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        filter_we  = 1'b0;
        filter_re  = 1'b0;
        rst_filter = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = filt_base_addr;
                    pass_d  = (num_passes == '0) ? PASS_W'(1) : num_passes;
                    word_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_rd    = 1'b1;
                mem_addr  = addr_q + ADDR_W'(word_q);
                filter_we = mem_ack;
                if (mem_ack) begin
                    word_d = word_q + 2'd1;
                    if (word_q == 2'd3) state_d = PRIME;
                end
            end
            PRIME: begin
                rst_filter = 1'b1;
                byte_d     = '0;
                state_d    = STREAM;
            end
            STREAM: begin
                filter_re = byte_ready;
                if (byte_ready) begin
                    byte_d = byte_q + 4'd1;
                    if (byte_q == 4'd15) begin
                        if (pass_q > PASS_W'(1)) begin
                            pass_d  = pass_q - PASS_W'(1);
                            state_d = PRIME;
                        end else begin
                            state_d = FINISH;
                        end
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign byte_valid = byte_valid_q;
    assign byte_idx   = byte_idx_q;
    assign pass_last  = pass_last_q;
    assign done       = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_filter_buffer_ctrl.sv
// Randomized bench for filter_buffer_ctrl with a memory responder,
// a 128-bit shift-buffer model and a byte-sequence reference queue.
module tb_filter_buffer_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  filt_base_addr;
    logic [7:0]  num_passes;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic        filter_we;
    logic        filter_re;
    logic        rst_filter;
    logic        byte_ready;
    logic        byte_valid;
    logic [3:0]  byte_idx;
    logic        pass_last;
    logic        busy;
    logic        done;

    logic [31:0] mem_data;
    logic [31:0] mem [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    filter_buffer_ctrl #(.ADDR_W(8), .PASS_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .filt_base_addr(filt_base_addr), .num_passes(num_passes),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .filter_we(filter_we), .filter_re(filter_re),
        .rst_filter(rst_filter), .byte_ready(byte_ready),
        .byte_valid(byte_valid), .byte_idx(byte_idx),
        .pass_last(pass_last), .busy(busy), .done(done)
    );

    logic [19:0] outs_v;
    assign outs_v = {mem_rd, mem_addr, filter_we, filter_re, rst_filter,
                     byte_valid, byte_idx, pass_last, busy, done};

    // Filter buffer: words shift in, bytes come out MSB-first, registered
    logic [127:0] fbuf = '0;
    logic [3:0]   rptr = '0;
    logic [7:0]   bbyte = '0;
    always @(posedge clk) begin
        if (filter_we) fbuf <= {fbuf[95:0], mem_data};
        if (rst_filter) rptr <= '0;
        else if (filter_re) rptr <= rptr + 4'd1;
        if (filter_re) bbyte <= fbuf[{4'd15 - rptr, 3'b000} +: 8];
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [3:0] idx;
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t q[$];

    task automatic run_job(input logic [7:0] base, input logic [7:0] np,
                           input int wait_n, input int ready_pct,
                           input bit junk_start, input bit abort7);
        int  n;
        int  lat;
        int  wcnt = 0;
        int  we_cnt = 0;
        int  rf_cnt = 0;
        bit  got_done = 0;
        bit  aborted = 0;
        exp_t e;
        n   = (np == 0) ? 1 : int'(np);
        lat = wait_n + 1;
        q.delete();
        for (int p = 0; p < n; p++) begin
            for (int k = 0; k < 16; k++) begin
                logic [7:0]  a;
                logic [31:0] w;
                exp_t        x;
                a = base + 8'(k / 4);
                w = mem[a];
                x.idx  = 4'(k);
                x.data = w[8*(3 - k % 4) +: 8];
                x.last = (p == n - 1);
                q.push_back(x);
            end
        end
        for (int c = 0; c < 3000 && !got_done && !aborted; c++) begin
            @(negedge clk);
            if (c == 0) begin
                start = 1'b1;
                filt_base_addr = base;
                num_passes = np;
            end else begin
                start = junk_start && ($urandom_range(0, 1) == 1);
                filt_base_addr = 8'($urandom);
                num_passes = 8'($urandom);
            end
            byte_ready = ($urandom_range(1, 100) <= ready_pct);
            mem_ack = 1'b0;
            if (mem_rd) begin
                if (wcnt == wait_n) begin
                    mem_ack = 1'b1;
                    mem_data = mem[mem_addr];
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            #1;
            if (filter_we) begin
                check("mem_addr", 32'(mem_addr), 32'(8'(base + 8'(we_cnt))));
                check("we_re_excl", 32'(filter_re), 0);
                we_cnt++;
            end
            if (!byte_ready) check("re_stall", 32'(filter_re), 0);
            if (rst_filter) begin
                check("rst_excl", 32'(filter_we | filter_re), 0);
                rf_cnt++;
            end
            if (byte_valid) begin
                if (q.size() == 0) begin
                    check("extra_byte", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("byte_idx", 32'(byte_idx), 32'(e.idx));
                    check("byte_data", 32'(bbyte), 32'(e.data));
                    check("pass_last", 32'(pass_last), 32'(e.last));
                    if (abort7 && e.idx == 4'd7) begin
                        #2;
                        rst_n = 1'b0;
                        #1;
                        check("abort_outs", 32'(outs_v), 0);
                        aborted = 1;
                        @(negedge clk);
                        start = 1'b0;
                        mem_ack = 1'b0;
                        rst_n = 1'b1;
                    end
                end
            end
            if (done && !aborted) begin
                got_done = 1;
                if (ready_pct == 100)
                    check("job_len", c, 4 * lat + 17 * n + 1);
            end
        end
        if (!aborted) begin
            check("done_seen", 32'(got_done), 1);
            check("bytes_left", q.size(), 0);
            check("we_count", we_cnt, 4);
            check("rst_filter_cnt", rf_cnt, n);
            @(negedge clk);
            start = 1'b0;
            mem_ack = 1'b0;
            #1;
            check("done_pulse", 32'(done), 0);
            check("idle_after", 32'(busy), 0);
        end
        start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        filt_base_addr = '0;
        num_passes = '0;
        mem_ack = 1'b0;
        mem_data = '0;
        byte_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outs", 32'(outs_v), 0);
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        mem_ack = 1'b1;
        mem_data = 32'hDEADBEEF;
        #1;
        check("spurious_we", 32'(filter_we), 0);
        check("spurious_busy", 32'(busy), 0);
        @(negedge clk);
        mem_ack = 1'b0;

        run_job(8'h10, 8'd1, 0, 100, 0, 0);
        run_job(8'h20, 8'd3, 0, 100, 0, 0);
        run_job(8'h30, 8'd2, 2, 50, 0, 0);
        run_job(8'h40, 8'd0, 0, 100, 0, 0);
        run_job(8'hFE, 8'd1, 1, 100, 0, 0);
        run_job(8'h50, 8'd2, 0, 100, 1, 0);
        run_job(8'h60, 8'd1, 0, 100, 0, 1);
        for (int i = 8'h60; i < 8'h64; i++) mem[i] = $urandom;
        run_job(8'h60, 8'd1, 0, 100, 0, 0);
        repeat (6) begin
            run_job(8'($urandom), 8'($urandom_range(0, 4)),
                    $urandom_range(0, 2),
                    ($urandom_range(0, 1) == 1) ? 100 : 60,
                    1'($urandom_range(0, 1)), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
